// File: rtl/tw_gen.sv
// ---------------------------------------------------------------------------
// tw_gen: twiddle-factor source for one radix-2 DIF SDF FFT stage.
// Tracks each sample's frame position and issues the matching Q1.7 twiddle
// (+1.0 = 128) two cycles later, aligned with data delayed by two registers.
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous reset, active low
//   start     frame sync; the sample accepted this cycle is position 0
//   in_valid  a data sample enters the stage this cycle
//   inverse   1 = IFFT (conjugate twiddle); sampled with in_valid
//   tw_valid  twiddle valid (in_valid delayed 2 cycles)
//   tw_re     twiddle real part, signed Q1.7
//   tw_im     twiddle imaginary part, signed Q1.7
//   tw_last   with tw_valid: twiddle belongs to frame position N-1
// ---------------------------------------------------------------------------
module tw_gen #(
    parameter int unsigned N     = 64,
    parameter int unsigned STAGE = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    input  logic              inverse,
    output logic              tw_valid,
    output logic signed [8:0] tw_re,
    output logic signed [8:0] tw_im,
    output logic              tw_last
);

    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned KW   = LOGN - 1;   // k lies in [0, N/2)
    localparam int unsigned QTR  = N / 4;
    localparam longint      ONE  = 64'sd268435456;   // 1.0 in Q.28
    localparam longint      PI_FX = 64'sd843314857;  // pi in Q.28

    // round(128*cos(2*pi*j/N)), ties away from zero, via integer Taylor series
    function automatic int cos_q7(input int unsigned j);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        int     res;
        x    = (2 * PI_FX * longint'(j)) / longint'(N);
        x2   = (x * x) / ONE;
        term = ONE;
        sum  = ONE;
        for (int n = 1; n <= 10; n++) begin
            term = -((term * x2) / ONE) / longint'((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        r = sum * 128 + ONE / 2;
        if (r < 0) res = 0;
        else       res = int'(r / ONE);
        cos_q7 = res;
    endfunction

    // Quarter-wave cosine table, fixed at elaboration
    logic signed [8:0] cos_rom [QTR+1];
    for (genvar j = 0; j <= QTR; j++) begin : g_rom
        localparam logic signed [8:0] CJ = 9'(cos_q7(j));
        assign cos_rom[j] = CJ;
    end

    logic [LOGN-1:0] cnt_q, cnt_d;
    logic [LOGN-1:0] pos;
    logic [LOGN-1:0] shifted;
    logic [KW-1:0]   k_d, k_q;
    logic            is_last;
    logic            v1_q, inv1_q, last1_q;

    // Frame position and next counter value
    always_comb begin
        pos   = start ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (in_valid) begin
            cnt_d = (pos == LOGN'(N - 1)) ? '0 : pos + LOGN'(1);
        end else if (start) begin
            cnt_d = '0;
        end
    end

    // (pos mod L) << STAGE equals (pos << STAGE) mod N; its top bit marks the
    // twiddled half and the remaining bits are k directly.
    always_comb begin
        shifted = pos << STAGE;
        k_d     = shifted[LOGN-1] ? shifted[KW-1:0] : '0;
        is_last = (pos == LOGN'(N - 1));
    end

    // Stage 1: counter and index registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            v1_q    <= 1'b0;
            k_q     <= '0;
            inv1_q  <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            v1_q  <= in_valid;
            if (in_valid) begin
                k_q     <= k_d;
                inv1_q  <= inverse;
                last1_q <= is_last;
            end
        end
    end

    logic              lo;
    logic [KW-1:0]     idx_re, idx_im;
    logic signed [8:0] mag_re, mag_im, re_d, im_d;

    // Quadrant folding: N/2-k wraps to -k in KW bits
    always_comb begin
        lo     = (k_q < KW'(QTR));
        idx_re = lo ? k_q : (KW'(0) - k_q);
        idx_im = lo ? (KW'(QTR) - k_q) : (k_q - KW'(QTR));
        mag_re = cos_rom[idx_re];
        mag_im = cos_rom[idx_im];
        re_d   = lo ? mag_re : -mag_re;
        im_d   = inv1_q ? mag_im : -mag_im;
    end

    // Stage 2: registered outputs, values hold between valid beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tw_valid <= 1'b0;
            tw_re    <= '0;
            tw_im    <= '0;
            tw_last  <= 1'b0;
        end else begin
            tw_valid <= v1_q;
            if (v1_q) begin
                tw_re   <= re_d;
                tw_im   <= im_d;
                tw_last <= last1_q;
            end
        end
    end

endmodule

// File: tb/tb_tw_gen.sv
// ---------------------------------------------------------------------------
// tb_tw_gen: scoreboard bench for tw_gen. One instance per (N, STAGE) for
// N in {8, 64, 512}; all share the same stimulus. Expected twiddles come from
// a $cos/$sin model, pushed at input time and popped when due.
// ---------------------------------------------------------------------------
module tb_tw_gen;

    localparam real PI = 3.14159265358979323846;

    logic clk      = 1'b0;
    logic rstn     = 1'b0;
    logic start    = 1'b0;
    logic in_valid = 1'b0;
    logic inverse  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int due;
        int pos;
        int re;
        int im;
        int last;
    } exp_t;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    for (genvar a = 0; a < 3; a++) begin : g_n
        localparam int unsigned NV = (a == 0) ? 8 : ((a == 1) ? 64 : 512);
        localparam int unsigned LG = $clog2(NV);
        for (genvar s = 0; s < LG; s++) begin : g_s
            localparam int unsigned LV = NV >> s;

            logic              tw_valid;
            logic              tw_last;
            logic signed [8:0] tw_re;
            logic signed [8:0] tw_im;

            exp_t q[$];
            int   mcnt      = 0;
            int   hold_re   = 0;
            int   hold_im   = 0;
            int   hold_last = 0;
            int   obs_re   [NV];
            int   obs_im   [NV];
            int   obs_last [NV];

            tw_gen #(.N(NV), .STAGE(s)) u_dut (
                .clk      (clk),
                .rstn     (rstn),
                .start    (start),
                .in_valid (in_valid),
                .inverse  (inverse),
                .tw_valid (tw_valid),
                .tw_re    (tw_re),
                .tw_im    (tw_im),
                .tw_last  (tw_last)
            );

            // Reference model: position tracking and twiddle per accepted sample
            always @(posedge clk or negedge rstn) begin : push
                int   pos;
                int   p;
                int   k;
                real  th;
                exp_t e;
                if (!rstn) begin
                    mcnt = 0;
                    q.delete();
                end else begin
                    pos = start ? 0 : mcnt;
                    if (in_valid) begin
                        p  = pos % LV;
                        k  = (p < LV / 2) ? 0 : ((p - LV / 2) << s);
                        th = 2.0 * PI * k / NV;
                        e.due  = cyc + 2;
                        e.pos  = pos;
                        e.re   = rnd(128.0 * $cos(th));
                        e.im   = -rnd(128.0 * $sin(th));
                        if (inverse) e.im = -e.im;
                        e.last = (pos == NV - 1) ? 1 : 0;
                        q.push_back(e);
                        mcnt = (pos == NV - 1) ? 0 : pos + 1;
                    end else if (start) begin
                        mcnt = 0;
                    end
                end
            end

            always @(negedge clk) begin : check
                exp_t  e;
                string nm;
                nm = $sformatf("N%0d_S%0d", NV, s);
                if (!rstn) begin
                    chk({nm, "_rst_valid"}, int'(tw_valid), 0);
                    chk({nm, "_rst_re"}, int'(tw_re), 0);
                    chk({nm, "_rst_im"}, int'(tw_im), 0);
                    chk({nm, "_rst_last"}, int'(tw_last), 0);
                    hold_re   = 0;
                    hold_im   = 0;
                    hold_last = 0;
                end else if (q.size() != 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk($sformatf("%s_p%0d_valid", nm, e.pos), int'(tw_valid), 1);
                    chk($sformatf("%s_p%0d_re", nm, e.pos), int'(tw_re), e.re);
                    chk($sformatf("%s_p%0d_im", nm, e.pos), int'(tw_im), e.im);
                    chk($sformatf("%s_p%0d_last", nm, e.pos), int'(tw_last), e.last);
                    hold_re   = e.re;
                    hold_im   = e.im;
                    hold_last = e.last;
                    obs_re[e.pos]   = int'(tw_re);
                    obs_im[e.pos]   = int'(tw_im);
                    obs_last[e.pos] = int'(tw_last);
                end else begin
                    chk({nm, "_idle_valid"}, int'(tw_valid), 0);
                    chk({nm, "_hold_re"}, int'(tw_re), hold_re);
                    chk({nm, "_hold_im"}, int'(tw_im), hold_im);
                    chk({nm, "_hold_last"}, int'(tw_last), hold_last);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic s, input logic inv);
        in_valid = v;
        start    = s;
        inverse  = inv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int pat [6] = '{1, 0, 0, 1, 1, 0};
        int nv;
        int i;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Full frame after start, forward transform
        drive(1'b1, 1'b1, 1'b0);
        for (int j = 1; j < 64; j++) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("t1_p0_re",   g_n[1].g_s[0].obs_re[0], 128);
        chk("t1_p0_im",   g_n[1].g_s[0].obs_im[0], 0);
        chk("t1_p31_re",  g_n[1].g_s[0].obs_re[31], 128);
        chk("t1_p32_re",  g_n[1].g_s[0].obs_re[32], 128);
        chk("t1_p32_im",  g_n[1].g_s[0].obs_im[32], 0);
        chk("t1_p40_re",  g_n[1].g_s[0].obs_re[40], 91);
        chk("t1_p40_im",  g_n[1].g_s[0].obs_im[40], -91);
        chk("t1_p48_re",  g_n[1].g_s[0].obs_re[48], 0);
        chk("t1_p48_im",  g_n[1].g_s[0].obs_im[48], -128);
        chk("t1_p56_re",  g_n[1].g_s[0].obs_re[56], -91);
        chk("t1_p56_im",  g_n[1].g_s[0].obs_im[56], -91);
        chk("t1_p62_last", g_n[1].g_s[0].obs_last[62], 0);
        chk("t1_p63_last", g_n[1].g_s[0].obs_last[63], 1);
        chk("t2_p16_re",  g_n[1].g_s[1].obs_re[16], 128);
        chk("t2_p16_im",  g_n[1].g_s[1].obs_im[16], 0);
        chk("t2_p24_re",  g_n[1].g_s[1].obs_re[24], 0);
        chk("t2_p24_im",  g_n[1].g_s[1].obs_im[24], -128);
        chk("t2_p48_re",  g_n[1].g_s[1].obs_re[48], 128);
        chk("t2_p56_re",  g_n[1].g_s[1].obs_re[56], 0);
        chk("t2_p56_im",  g_n[1].g_s[1].obs_im[56], -128);
        chk("n8_p5_re",   g_n[0].g_s[0].obs_re[5], 91);
        chk("n8_p6_im",   g_n[0].g_s[0].obs_im[6], -128);

        // Inverse toggled per sample (set on even positions)
        drive(1'b1, 1'b1, 1'b1);
        for (int j = 1; j < 64; j++) drive(1'b1, 1'b0, logic'(j % 2 == 0));
        idle(3);
        chk("t3_p40_re", g_n[1].g_s[0].obs_re[40], 91);
        chk("t3_p40_im", g_n[1].g_s[0].obs_im[40], 91);
        chk("t3_p48_re", g_n[1].g_s[0].obs_re[48], 0);
        chk("t3_p48_im", g_n[1].g_s[0].obs_im[48], 128);
        chk("t3_p41_im", g_n[1].g_s[0].obs_im[41], -99);
        chk("t3_p56_im", g_n[1].g_s[0].obs_im[56], 91);

        // Partial frame, start without valid, then gapped valids
        for (int j = 0; j < 10; j++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        nv = 0;
        i  = 0;
        while (nv < 64) begin
            drive(logic'(pat[i % 6]), 1'b0, 1'b0);
            nv = nv + pat[i % 6];
            i++;
        end
        idle(3);
        chk("t4_p40_re",   g_n[1].g_s[0].obs_re[40], 91);
        chk("t4_p48_im",   g_n[1].g_s[0].obs_im[48], -128);
        chk("t4_p63_last", g_n[1].g_s[0].obs_last[63], 1);

        // Start mid-frame at position 20
        drive(1'b1, 1'b1, 1'b0);
        for (int j = 1; j < 20; j++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        for (int j = 1; j < 69; j++) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("t5_p32_re",   g_n[1].g_s[0].obs_re[32], 128);
        chk("t5_p32_im",   g_n[1].g_s[0].obs_im[32], 0);
        chk("t5_p63_last", g_n[1].g_s[0].obs_last[63], 1);

        // Asynchronous reset between edges mid-frame
        drive(1'b1, 1'b1, 1'b0);
        for (int j = 1; j < 45; j++) drive(1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_async_valid", int'(g_n[1].g_s[0].tw_valid), 0);
        chk("t6_async_re",    int'(g_n[1].g_s[0].tw_re), 0);
        chk("t6_async_im",    int'(g_n[1].g_s[0].tw_im), 0);
        chk("t6_async_last",  int'(g_n[1].g_s[0].tw_last), 0);
        @(negedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 64; j++) drive(1'b1, 1'b0, 1'b0);
        idle(3);
        chk("t6_p0_re",    g_n[1].g_s[0].obs_re[0], 128);
        chk("t6_p40_re",   g_n[1].g_s[0].obs_re[40], 91);
        chk("t6_p40_im",   g_n[1].g_s[0].obs_im[40], -91);
        chk("t6_p62_last", g_n[1].g_s[0].obs_last[62], 0);
        chk("t6_p63_last", g_n[1].g_s[0].obs_last[63], 1);

        // Random sweep: long enough to wrap every N, with gaps and rare starts
        for (int j = 0; j < 1200; j++) begin
            drive(logic'($urandom_range(0, 7) != 0),
                  logic'($urandom_range(0, 299) == 0),
                  logic'($urandom_range(0, 1)));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
